// File: rtl/universal_shift_reg_if.sv
// universal_shift_reg_if: datapath bundle for universal_shift_reg
//   master drives mode/en/d/sl_in/sr_in/start/cnt and observes q/so_l/so_r/busy/done
//   slave is the register side; zero exists only when SHREG_ZERO_FLAG_EN is defined
interface universal_shift_reg_if #(parameter int W = 8, parameter int CW = 4);
  logic [2:0]    mode;
  logic          en;
  logic [W-1:0]  d;
  logic          sl_in;
  logic          sr_in;
  logic          start;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q;
  logic          so_l;
  logic          so_r;
  logic          busy;
  logic          done;
`ifdef SHREG_ZERO_FLAG_EN
  logic          zero;
  modport master(output mode, en, d, sl_in, sr_in, start, cnt,
                 input q, so_l, so_r, busy, done, zero);
  modport slave(input mode, en, d, sl_in, sr_in, start, cnt,
                output q, so_l, so_r, busy, done, zero);
`else
  modport master(output mode, en, d, sl_in, sr_in, start, cnt,
                 input q, so_l, so_r, busy, done);
  modport slave(input mode, en, d, sl_in, sr_in, start, cnt,
                output q, so_l, so_r, busy, done);
`endif
endinterface

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: W-bit universal shift register with burst engine, falling-edge clocked
//   clk  : clock, state updates on the falling edge
//   rst  : asynchronous active-low reset
//   bus  : universal_shift_reg_if.slave (mode/en/d/sl_in/sr_in/start/cnt in; q/so_l/so_r/busy/done out)
//   SHREG_ZERO_FLAG_EN adds the registered bus.zero flag (next q all zeros, reset 1)
module universal_shift_reg #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input logic clk,
  input logic rst,
  universal_shift_reg_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t        state, state_nx;
  logic [W-1:0]  q_r, q_nx;
  logic [2:0]    lmode, lmode_nx;
  logic [CW-1:0] rem, rem_nx;
  logic          busy_r, busy_nx;
  logic          done_r, done_nx;
  function automatic logic [W-1:0] apply(input logic [2:0] m, input logic [W-1:0] v,
                                         input logic [W-1:0] ld, input logic sl, input logic sr);
    case (m)
      3'b001:  return {v[W-2:0], sl};
      3'b010:  return {sr, v[W-1:1]};
      3'b011:  return ld;
      3'b100:  return {v[W-2:0], v[W-1]};
      3'b101:  return {v[0], v[W-1:1]};
      3'b110:  return {v[W-1], v[W-1:1]};
      3'b111:  return '0;
      default: return v;
    endcase
  endfunction
  // rem counts ops still owed after the current edge; the edge that sees rem==1 is the last one
  always_comb begin
    state_nx = state;
    q_nx     = q_r;
    lmode_nx = lmode;
    rem_nx   = rem;
    busy_nx  = busy_r;
    done_nx  = 1'b0;
    if (state == BURST) begin
      q_nx   = apply(lmode, q_r, bus.d, bus.sl_in, bus.sr_in);
      rem_nx = rem - 1'b1;
      if (rem == CW'(1)) begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
      end
    end else if (bus.start) begin
      if (bus.cnt == '0) begin
        done_nx = 1'b1;
      end else if (bus.mode inside {3'b000, 3'b011, 3'b111}) begin
        q_nx    = apply(bus.mode, q_r, bus.d, bus.sl_in, bus.sr_in);
        done_nx = 1'b1;
      end else begin
        q_nx     = apply(bus.mode, q_r, bus.d, bus.sl_in, bus.sr_in);
        lmode_nx = bus.mode;
        rem_nx   = bus.cnt - 1'b1;
        if (bus.cnt == CW'(1)) begin
          done_nx = 1'b1;
        end else begin
          state_nx = BURST;
          busy_nx  = 1'b1;
        end
      end
    end else if (bus.en) begin
      q_nx = apply(bus.mode, q_r, bus.d, bus.sl_in, bus.sr_in);
    end
  end
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      q_r    <= '0;
      lmode  <= '0;
      rem    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      q_r    <= q_nx;
      lmode  <= lmode_nx;
      rem    <= rem_nx;
      busy_r <= busy_nx;
      done_r <= done_nx;
    end
  end
`ifdef SHREG_ZERO_FLAG_EN
  logic zero_r;
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) zero_r <= 1'b1;
    else      zero_r <= (q_nx == '0);
  end
  assign bus.zero = zero_r;
`endif
  assign bus.q    = q_r;
  assign bus.so_l = q_r[W-1];
  assign bus.so_r = q_r[0];
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule
